// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset PC and fetch FSM state encoding for the MIPS fetch path.
package mips_pkg;
    localparam int PC_W = 13;
    localparam int INSTR_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 13'h0000;
    typedef enum logic [1:0] {IDLE, FETCH, VALID} fetch_state_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch sequencer.
//   i_pc            current PC
//   i_redir_valid   redirect request this cycle
//   i_redir_target  redirect target this cycle
//   i_pend_target   target latched by an earlier redirect during FETCH
//   i_slot_pend     deferred (delay-slot) target waiting   [PC_FETCH_DELAY_SLOT_EN]
//   i_slot_target   deferred target                        [PC_FETCH_DELAY_SLOT_EN]
//   o_slot_load     handshake redirect must be deferred    [PC_FETCH_DELAY_SLOT_EN]
//   o_hs_pc         PC to load at a decode handshake
//   o_fetch_pc      PC to reload when a redirected fetch is discarded
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_redir_valid,
    input  logic [PC_W-1:0] i_redir_target,
    input  logic [PC_W-1:0] i_pend_target,
`ifdef PC_FETCH_DELAY_SLOT_EN
    input  logic            i_slot_pend,
    input  logic [PC_W-1:0] i_slot_target,
    output logic            o_slot_load,
`endif
    output logic [PC_W-1:0] o_hs_pc,
    output logic [PC_W-1:0] o_fetch_pc
);
    logic [PC_W-1:0] w_seq_pc;

    // Wraps modulo 2^PC_W by width truncation.
    assign w_seq_pc   = i_pc + PC_W'(1);
    // A redirect arriving on the ack cycle itself is the most recent one, so it wins.
    assign o_fetch_pc = i_redir_valid ? i_redir_target : i_pend_target;
`ifdef PC_FETCH_DELAY_SLOT_EN
    // A waiting slot target overrides any redirect offered at this handshake.
    assign o_slot_load = i_redir_valid && !i_slot_pend;
    assign o_hs_pc     = i_slot_pend ? i_slot_target : w_seq_pc;
`else
    assign o_hs_pc     = i_redir_valid ? i_redir_target : w_seq_pc;
`endif
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches words over req/ack and hands them to decode over valid/ready.
//   clk, rst                      clock, async active-high reset
//   run, halt                     run level, stop-after-handoff pulse
//   imem_req/addr/ack/rdata       instruction memory handshake
//   instr_valid/ready, instr, instr_pc   decode handshake and held instruction
//   redirect_valid/target         branch/jump redirect
//   busy                          sequencer not idle
// Optional: PC_FETCH_DELAY_SLOT_EN defers a handshake redirect by one instruction.
module pc_fetch_sequencer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               busy
);
    fetch_state_t       r_state;
    fetch_state_t       w_state_nx;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_halt_pend;
    logic               r_redir_pend;
    logic [PC_W-1:0]    r_redir_tgt;
    logic               w_redir;
    logic               w_stop;
    logic [PC_W-1:0]    w_hs_pc;
    logic [PC_W-1:0]    w_fetch_pc;
`ifdef PC_FETCH_DELAY_SLOT_EN
    logic               r_slot_pend;
    logic [PC_W-1:0]    r_slot_tgt;
    logic               w_slot_load;
`endif

    // Any redirect seen during this fetch, including one on the ack cycle, discards its data.
    assign w_redir = r_redir_pend || redirect_valid;
    assign w_stop  = halt || r_halt_pend || !run;

    pc_next_sel u_next (
        .i_pc           (r_pc),
        .i_redir_valid  (redirect_valid),
        .i_redir_target (redirect_target),
        .i_pend_target  (r_redir_tgt),
`ifdef PC_FETCH_DELAY_SLOT_EN
        .i_slot_pend    (r_slot_pend),
        .i_slot_target  (r_slot_tgt),
        .o_slot_load    (w_slot_load),
`endif
        .o_hs_pc        (w_hs_pc),
        .o_fetch_pc     (w_fetch_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = run ? FETCH : IDLE;
            FETCH:   w_state_nx = (imem_ack && !w_redir) ? VALID : FETCH;
            VALID:   w_state_nx = instr_ready ? (w_stop ? IDLE : FETCH) : VALID;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_halt_pend  <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= '0;
`ifdef PC_FETCH_DELAY_SLOT_EN
            r_slot_pend  <= 1'b0;
            r_slot_tgt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (redirect_valid) r_pc <= redirect_target;
                FETCH: begin
                    if (halt) r_halt_pend <= 1'b1;
                    if (redirect_valid) begin
                        r_redir_pend <= 1'b1;
                        r_redir_tgt  <= redirect_target;
                    end
                    // Later assignment to r_redir_pend wins: the ack consumes the pending redirect.
                    if (imem_ack && w_redir) begin
                        r_pc         <= w_fetch_pc;
                        r_redir_pend <= 1'b0;
                    end else if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                    end
                end
                VALID: begin
                    if (halt) r_halt_pend <= 1'b1;
                    if (instr_ready) begin
                        r_pc        <= w_hs_pc;
                        r_halt_pend <= 1'b0;
`ifdef PC_FETCH_DELAY_SLOT_EN
                        r_slot_pend <= w_slot_load;
                        if (w_slot_load) r_slot_tgt <= redirect_target;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = r_state == FETCH;
    assign imem_addr   = r_pc;
    assign instr_valid = r_state == VALID;
    assign busy        = r_state != IDLE;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed and randomized checks of the fetch sequencer against a transaction-level model.
module tb_pc_fetch_sequencer;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst, run, halt, imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, busy;
    logic [PC_W-1:0] imem_addr, instr_pc, redirect_target;
    logic [INSTR_W-1:0] imem_rdata, instr;

    int errors = 0;
    int checks = 0;

    logic [PC_W-1:0] exp_pc, req_addr, fetched_pc, slot_tgt_m, vr_pc, vr_tgt, ff_pc, ff_tgt;
    bit req_on, discard, valid_exp, slot_m, vr_en, ff_en, do_halt, drop_run, halting, idle_next;
    int lat, cur_lat, ack_wait, ready_pct, vr_pct, fr_pct, n_hs, n_idle;
    logic [PC_W-1:0] hist[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .busy            (busy)
    );

    function automatic logic [31:0] mem(input logic [PC_W-1:0] a);
        return (32'(a) * 32'd2654435761) ^ 32'h5EED_0000;
    endfunction

    function automatic logic [PC_W-1:0] rnd13();
        return PC_W'($urandom_range(0, 8191));
    endfunction

    function automatic bit seq(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
        for (int i = 0; i + 1 < hist.size(); i++)
            if (hist[i] == a && hist[i+1] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count(input logic [PC_W-1:0] a);
        int c = 0;
        foreach (hist[i]) if (hist[i] == a) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_pc = RESET_PC; req_on = 0; discard = 0; valid_exp = 0; slot_m = 0;
        halting = 0; idle_next = 0; do_halt = 0; drop_run = 0; vr_en = 0; ff_en = 0;
    endtask

    // Next fetch address after delivering fetched_pc, straight from the redirect rules.
    task automatic model_hs(input bit r, input logic [PC_W-1:0] t);
`ifdef PC_FETCH_DELAY_SLOT_EN
        if (slot_m) begin
            exp_pc = slot_tgt_m;
            slot_m = 0;
        end else begin
            exp_pc = fetched_pc + 13'd1;
            if (r) begin slot_m = 1; slot_tgt_m = t; end
        end
`else
        exp_pc = r ? t : fetched_pc + 13'd1;
`endif
    endtask

    task automatic cyc();
        bit r;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        chk("valid", 32'(instr_valid), 32'(valid_exp));
        if (idle_next) begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_req", 32'(imem_req), 0);
            idle_next = 0;
            n_idle++;
        end
        if (imem_req) begin
            if (!req_on) begin
                chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
                req_on = 1; req_addr = exp_pc; ack_wait = 0;
                cur_lat = lat < 0 ? int'($urandom_range(0, 3)) : lat;
            end
            if (do_halt) begin halt = 1'b1; do_halt = 0; halting = 1; end
            if (drop_run) begin run = 1'b0; drop_run = 0; end
            r = ff_en && req_addr == ff_pc;
            if (r || int'($urandom_range(0, 99)) < fr_pct) begin
                redirect_valid = 1'b1;
                redirect_target = r ? ff_tgt : rnd13();
                exp_pc = redirect_target;
                discard = 1;
                if (r) ff_en = 0;
            end
            if (ack_wait >= cur_lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem(imem_addr);
                req_on = 0;
                if (!discard) begin fetched_pc = req_addr; valid_exp = 1; end
                discard = 0;
            end else ack_wait++;
        end
        if (instr_valid) begin
            chk("instr_pc", 32'(instr_pc), 32'(fetched_pc));
            chk("instr", instr, mem(fetched_pc));
            chk("req_in_valid", 32'(imem_req), 0);
            instr_ready = int'($urandom_range(0, 99)) < ready_pct;
            if (instr_ready) begin
                r = vr_en && fetched_pc == vr_pc;
                if (r || int'($urandom_range(0, 99)) < vr_pct) begin
                    redirect_valid = 1'b1;
                    redirect_target = r ? vr_tgt : rnd13();
                    if (r) vr_en = 0;
                end
                model_hs(redirect_valid, redirect_target);
                hist.push_back(fetched_pc);
                n_hs++;
                valid_exp = 0;
                if (halting || !run) idle_next = 1;
                halting = 0;
            end
        end
    endtask

    task automatic wait_valid();
        ready_pct = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (instr_valid) break;
        end
        chk("wait_valid", 32'(instr_valid), 1);
    endtask

    initial begin
        int n0, c9, i0;
        rst = 1'b1; run = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        lat = 0; ready_pct = 100; vr_pct = 0; fr_pct = 0; n_hs = 0; n_idle = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);

        run = 1'b1;
        n0 = n_hs;
        repeat (8) cyc();
        chk("rate", 32'(n_hs - n0), 4);
        chk("seq01", 32'(seq(0, 1)), 1);
        chk("seq23", 32'(seq(2, 3)), 1);

        vr_en = 1; vr_pc = 13'd5; vr_tgt = 13'h0040;
        repeat (12) cyc();
`ifdef PC_FETCH_DELAY_SLOT_EN
        chk("slot_seq", 32'(seq(5, 6) && seq(6, 13'h0040)), 1);
`else
        chk("redir_seq", 32'(seq(5, 13'h0040)), 1);
`endif

        wait_valid();
        repeat (4) cyc();

        c9 = count(13'd9);
        vr_en = 1; vr_pc = fetched_pc; vr_tgt = 13'd9;
        ff_en = 1; ff_pc = 13'd9; ff_tgt = 13'h0100;
        lat = 3; ready_pct = 100;
        repeat (24) cyc();
        chk("ff_taken", 32'(ff_en), 0);
        chk("no_pc9", 32'(count(13'd9)), 32'(c9));
        chk("got_100", 32'(count(13'h0100) > 0), 1);

        lat = 0;
        wait_valid();
        vr_en = 1; vr_pc = fetched_pc; vr_tgt = 13'h1FFF; ready_pct = 100;
        repeat (10) cyc();
        chk("wrap", 32'(seq(13'h1FFF, 13'h0000)), 1);

        n0 = n_idle;
        do_halt = 1;
        repeat (8) cyc();
        chk("halt_idle", 32'(n_idle - n0), 1);

        drop_run = 1;
        repeat (8) cyc();
        chk("stop_busy", 32'(busy), 0);
        chk("stop_req", 32'(imem_req), 0);
        redirect_valid = 1'b1; redirect_target = 13'h0020; exp_pc = 13'h0020;
        cyc();
        run = 1'b1;
        n0 = hist.size();
        repeat (6) cyc();
        chk("idle_redir", 32'(hist.size() > n0 ? hist[n0] : 13'h1ABC), 32'h20);

        lat = 5;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (imem_req) break;
        end
        #2 rst = 1'b1; run = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_instr", instr, 0);
        chk("arst_instr_pc", 32'(instr_pc), 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stray_ack_valid", 32'(instr_valid), 0);
            chk("stray_ack_busy", 32'(busy), 0);
        end
        reset_model();
        imem_ack = 1'b0; lat = 0; run = 1'b1;
        n0 = hist.size();
        repeat (6) cyc();
        chk("restart_pc", 32'(hist.size() > n0 ? hist[n0] : 13'h1ABC), 0);

        lat = -1; ready_pct = 70; vr_pct = 25; fr_pct = 10;
        i0 = n_hs;
        repeat (400) cyc();
        chk("random_progress", 32'(n_hs - i0 >= 40), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the 13-bit program counter and sequences instruction fetch for the MIPS core.
- Issues word-address requests to instruction memory over a req/ack handshake and delivers each fetched instruction to decode over a valid/ready handshake.
- Selects the next PC from the sequential value (PC+1) or a redirect target supplied by branch/jump resolution.

Parameters:
- PC_W, 13, PC/word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 13'h0000, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; high permits fetching
- halt  in  1  pulse; stop after the current instruction is handed off
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (the current PC)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  INSTR_W  fetched word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts
- instr  out  INSTR_W  held instruction
- instr_pc  out  PC_W  address of the held instruction
- redirect_valid  in  1  branch taken / jump
- redirect_target  in  PC_W  absolute target
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state):
  - state=IDLE, pc=RESET_PC, all outputs 0, instr=0, instr_pc=0.
  - pending flags cleared.
  - An in-flight fetch is abandoned. A late imem_ack after reset is ignored in IDLE.
- IDLE:
  - imem_req=0.
  - When run=1, go to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: capture imem_rdata into instr and pc into instr_pc, then go to VALID.
  - Minimum latency is 1 cycle from entering FETCH to instr_valid.
- VALID:
  - instr_valid=1; instr and instr_pc are stable until the handshake completes.
  - On instr_valid&&instr_ready:
    - pc <= redirect_valid ? redirect_target : pc+1.
    - Next state is IDLE if (halt || halt_pend || !run), otherwise FETCH.
- Next-PC arithmetic: pc+1 is modulo 2^PC_W, so 13'h1FFF wraps to 13'h0000 with no flag.
- Redirect outside VALID:
  - In FETCH, redirect_valid sets redir_pend and latches the target.
  - The fetch completes (ack awaited) and its data is discarded; it is never presented.
  - pc <= latched target, redir_pend clears, FETCH repeats.
  - If several redirects arrive in FETCH, the last one wins.
- Redirect in IDLE: pc <= redirect_target immediately, used by the next run.
- halt:
  - In FETCH, sets halt_pend.
  - Taking effect at the next handshake means the instruction in flight is still delivered.
- run deasserted mid-FETCH: the fetch completes and is delivered; the sequencer stops after handoff.
- Same-cycle redirect and halt at handshake: the redirect updates pc, then the sequencer goes to IDLE, so a resume fetches from the target.
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro: PC_FETCH_DELAY_SLOT_EN.
- Defined:
  - A redirect accepted at the VALID handshake is deferred by one instruction.
  - pc <= pc+1, which is the delay slot; the target is held in slot_pend.
  - The following handshake loads the target, overriding that handshake's redirect_valid; a same-cycle redirect there is ignored.
  - Reset clears slot_pend.
- Undefined: the redirect applies immediately as described above, and the slot_pend logic is absent.

Decomposition:
- Shared package (mips_pkg):
  - PC_W, INSTR_W, RESET_PC.
  - State enum fetch_state_t {IDLE, FETCH, VALID}, 2 bits.
- Sub-module pc_next_sel: combinational next-PC selection (increment, wrap, redirect/pending/slot priority).
- FSM and registers stay in the top.

Test Plan:
- Reset then run=1 with ack same cycle as req, ready always high -> imem_addr 0,1,2,3; instr_pc matches; one instruction per 2 cycles.
- PC at 13'h1FFF, handshake with no redirect -> next imem_addr=13'h0000.
- redirect_valid=1, target 13'h0040 at the VALID handshake of pc 5 -> next imem_addr=13'h0040; no instruction from address 6 is delivered. With PC_FETCH_DELAY_SLOT_EN: 6 is delivered, then 13'h0040.
- Redirect to 13'h0100 during FETCH of pc 9, ack 3 cycles later -> address 9 data never valid; next imem_addr=13'h0100.
- instr_ready held low 4 cycles -> instr/instr_pc stable and imem_req=0 throughout. halt pulse in FETCH -> in-flight instruction delivered, then IDLE with busy=0.
- rst asserted mid-FETCH (async, between edges) -> outputs 0 immediately; a stray imem_ack is ignored; run restarts fetching at 13'h0000.
